// File: rtl/tug_victory.sv
// ---------------------------------------------------------------------------
// tug_victory -- round and match controller for the tug-of-war playfield.
//
// Watches the two end lights and the conditioned L/R press pulses, detects a
// round win, keeps per-player points, issues the round-clear pulse to every
// playfield light and drives two seven-segment score digits. The match is
// frozen once either player reaches MAX_SCORE; only reset restarts it.
//
// Optional feature macro: VICTORY_HOLD_EN
//   defined   : a HOLD phase of HOLD_CYCLES cycles follows each round win so
//               the winning end light stays visible before the clear.
//   undefined : a win goes straight to the clear; HOLD_CYCLES is unused.
//
// Parameters:
//   MAX_SCORE   points needed to win the match (1..9)
//   HOLD_CYCLES post-win hold length (>=1), used only with VICTORY_HOLD_EN
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   L, R       in   left/right press, one-cycle pulses
//   leftEnd    in   leftmost playfield light is lit
//   rightEnd   in   rightmost playfield light is lit
//   playAgain  out  one-cycle round-clear pulse
//   scoreL/R   out  player points (SW bits)
//   hexL/R     out  active-low seven-segment digits (g..a)
//   gameOver   out  match finished
//   winnerLeft out  valid with gameOver: 1 = left won
// ---------------------------------------------------------------------------
module tug_victory #(
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int SW         = $clog2(MAX_SCORE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          L,
  input  logic          R,
  input  logic          leftEnd,
  input  logic          rightEnd,
  output logic          playAgain,
  output logic [SW-1:0] scoreL,
  output logic [SW-1:0] scoreR,
  output logic [6:0]    hexL,
  output logic [6:0]    hexR,
  output logic          gameOver,
  output logic          winnerLeft
);

  // Elaboration-time guards on the parameter ranges.
  if (MAX_SCORE < 1 || MAX_SCORE > 9) begin : g_bad_max_score
    $error("tug_victory: MAX_SCORE must be in 1..9");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("tug_victory: HOLD_CYCLES must be >= 1");
  end

  localparam logic [SW-1:0] MAX_S = SW'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

`ifdef VICTORY_HOLD_EN
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam state_e WIN_NEXT = ST_HOLD;
`else
  localparam state_e WIN_NEXT = ST_POINT;
`endif

  // Saturating increment: a score never wraps past MAX_SCORE.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    if (v == MAX_S) begin
      r = v;
    end else begin
      r = v + SW'(1);
    end
    return r;
  endfunction

  // Active-low seven-segment decode, segment order g..a; >9 blanks.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  state_e        state_q, state_d;
  logic [SW-1:0] score_l_q, score_l_d;
  logic [SW-1:0] score_r_q, score_r_d;
  logic          last_left_q, last_left_d;
  logic          play_again_q, play_again_d;
  logic          game_over_q, game_over_d;
  logic          winner_left_q, winner_left_d;
`ifdef VICTORY_HOLD_EN
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic win_l_s;
  logic win_r_s;
  logic final_point_s;

  // Round-win detection. A simultaneous L/R press is a tie. Presses during
  // the clear cycle (playAgain high) are dropped: the lights are being
  // cleared and the end light may still read as lit.
  assign win_l_s = leftEnd  & L & ~R & ~play_again_q;
  assign win_r_s = rightEnd & R & ~L & ~play_again_q;

  // The point just scored belongs to the player recorded in last_left.
  assign final_point_s = last_left_q ? (score_l_q == MAX_S) : (score_r_q == MAX_S);

  // Next-state, scoring and output-register decode.
  always_comb begin
    state_d       = state_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    last_left_d   = last_left_q;
`ifdef VICTORY_HOLD_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    // Outputs are registered decodes of the current state so that no input
    // reaches an output combinationally.
    play_again_d  = (state_q == ST_POINT);
    game_over_d   = (state_q == ST_OVER);
    winner_left_d = (state_q == ST_OVER) & last_left_q;

    case (state_q)
      ST_PLAY: begin
        if (win_l_s) begin
          last_left_d = 1'b1;
          score_l_d   = sat_inc(score_l_q);
          state_d     = WIN_NEXT;
`ifdef VICTORY_HOLD_EN
          hold_cnt_d  = HOLD_LOAD;
`endif
        end else if (win_r_s) begin
          last_left_d = 1'b0;
          score_r_d   = sat_inc(score_r_q);
          state_d     = WIN_NEXT;
`ifdef VICTORY_HOLD_EN
          hold_cnt_d  = HOLD_LOAD;
`endif
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_HOLD: begin
`ifdef VICTORY_HOLD_EN
        // Leave one cycle after the counter has reached zero.
        if (hold_cnt_q == HW'(0)) begin
          state_d = ST_POINT;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
`else
        state_d = ST_PLAY;
`endif
      end
      ST_POINT: begin
        if (final_point_s) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      score_l_q     <= '0;
      score_r_q     <= '0;
      last_left_q   <= 1'b0;
      play_again_q  <= 1'b0;
      game_over_q   <= 1'b0;
      winner_left_q <= 1'b0;
`ifdef VICTORY_HOLD_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      last_left_q   <= last_left_d;
      play_again_q  <= play_again_d;
      game_over_q   <= game_over_d;
      winner_left_q <= winner_left_d;
`ifdef VICTORY_HOLD_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign playAgain  = play_again_q;
  assign gameOver   = game_over_q;
  assign winnerLeft = winner_left_q;
  assign scoreL     = score_l_q;
  assign scoreR     = score_r_q;
  assign hexL       = seg7(4'(score_l_q));
  assign hexR       = seg7(4'(score_r_q));

endmodule

// File: tb/tb_tug_victory.sv
module tb_tug_victory;

  localparam int MAX  = 7;
  localparam int HOLD = 4;
`ifdef VICTORY_HOLD_EN
  localparam int LAT = HOLD + 1;  // win edge -> playAgain visible
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, L, R, leftEnd, rightEnd;
  logic       playAgain, gameOver, winnerLeft;
  logic [2:0] scoreL, scoreR;
  logic [6:0] hexL, hexR;

  int checks = 0;
  int errors = 0;

  tug_victory #(.MAX_SCORE(MAX), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R),
    .leftEnd(leftEnd), .rightEnd(rightEnd),
    .playAgain(playAgain), .scoreL(scoreL), .scoreR(scoreR),
    .hexL(hexL), .hexR(hexR), .gameOver(gameOver), .winnerLeft(winnerLeft)
  );

  always #5 clk = ~clk;

  // Behavioural reference: rounds as events with fixed latencies.
  int cyc = 0;
  int m_l = 0, m_r = 0;
  bit m_last_left = 1'b0;
  bit m_done = 1'b0;
  int m_busy = 0;       // upcoming edges at which presses are ignored
  int m_pa_at = -1;     // edge after which playAgain is expected high
  int m_over_at = -1;   // edge after which gameOver is expected high

  function automatic logic [6:0] exp_hex(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Advance one clock: update the model from the inputs about to be
  // sampled, take the edge, and return at the following falling edge.
  task automatic tick();
    int e;
    e = cyc + 1;
    if (reset) begin
      m_l = 0; m_r = 0; m_last_left = 1'b0; m_done = 1'b0;
      m_busy = 0; m_pa_at = -1; m_over_at = -1;
    end else if (m_done) begin
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (leftEnd && L && !R) begin
      if (m_l < MAX) m_l++;
      m_last_left = 1'b1; m_pa_at = e + LAT; m_busy = LAT + 1;
      if (m_l == MAX) begin m_done = 1'b1; m_over_at = e + LAT + 1; end
    end else if (rightEnd && R && !L) begin
      if (m_r < MAX) m_r++;
      m_last_left = 1'b0; m_pa_at = e + LAT; m_busy = LAT + 1;
      if (m_r == MAX) begin m_done = 1'b1; m_over_at = e + LAT + 1; end
    end
    @(posedge clk);
    cyc = e;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (scoreL !== 3'd0) begin errors++; $display("FAIL reset_scoreL got %0d exp 0", scoreL); end
      checks++; if (scoreR !== 3'd0) begin errors++; $display("FAIL reset_scoreR got %0d exp 0", scoreR); end
      checks++; if (hexL !== 7'b1000000) begin errors++; $display("FAIL reset_hexL got %b exp 1000000", hexL); end
      checks++; if (hexR !== 7'b1000000) begin errors++; $display("FAIL reset_hexR got %b exp 1000000", hexR); end
      checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL reset_playAgain got %b exp 0", playAgain); end
      checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL reset_gameOver got %b exp 0", gameOver); end
      checks++; if (winnerLeft !== 1'b0) begin errors++; $display("FAIL reset_winnerLeft got %b exp 0", winnerLeft); end
    end
  endtask

  task automatic test_left_win();
    leftEnd = 1'b1; L = 1'b1;
    tick();  // win edge
    L = 1'b0;
    checks++; if (scoreL !== 3'd1) begin errors++; $display("FAIL win_scoreL got %0d exp 1", scoreL); end
    checks++; if (hexL !== 7'b1111001) begin errors++; $display("FAIL win_hexL got %b exp 1111001", hexL); end
    checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL win_pa_early got %b exp 0", playAgain); end
    // press right after the win (hold, or the point cycle) must be dropped
    L = 1'b1;
    tick();
    L = 1'b0;
    checks++; if (playAgain !== (LAT == 1)) begin errors++; $display("FAIL win_pa_e1 got %b exp %b", playAgain, (LAT == 1)); end
    for (int i = 2; i <= LAT; i++) begin
      tick();
      checks++; if (playAgain !== (i == LAT)) begin errors++; $display("FAIL win_pa_e%0d got %b exp %b", i, playAgain, (i == LAT)); end
    end
    // press during the clear cycle is dropped too
    L = 1'b1;
    tick();
    L = 1'b0;
    checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL win_pa_end got %b exp 0", playAgain); end
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL win_gameOver got %b exp 0", gameOver); end
    tick(); tick();
    checks++; if (scoreL !== 3'd1) begin errors++; $display("FAIL win_scoreL_after got %0d exp 1", scoreL); end
    checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL win_pa_after got %b exp 0", playAgain); end
    leftEnd = 1'b0;
  endtask

  task automatic test_tie();
    rightEnd = 1'b1; L = 1'b1; R = 1'b1;
    tick();
    L = 1'b0; R = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      checks++; if (scoreR !== 3'd0 || scoreL !== 3'd1) begin errors++; $display("FAIL tie_scores got %0d/%0d exp 1/0", scoreL, scoreR); end
      checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL tie_pa got %b exp 0", playAgain); end
    end
    L = 1'b1;
    tick();
    L = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      checks++; if (scoreR !== 3'd0 || scoreL !== 3'd1) begin errors++; $display("FAIL wrong_end_scores got %0d/%0d exp 1/0", scoreL, scoreR); end
      checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL wrong_end_pa got %b exp 0", playAgain); end
    end
    rightEnd = 1'b0;
  endtask

  task automatic test_match_over();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int w = 1; w <= MAX; w++) begin
      rightEnd = 1'b1; R = 1'b1;
      tick();
      R = 1'b0; rightEnd = 1'b0;
      checks++; if (scoreR !== 3'(w)) begin errors++; $display("FAIL over_scoreR got %0d exp %0d", scoreR, w); end
      repeat (LAT + 1) tick();
    end
    checks++; if (scoreR !== 3'd7) begin errors++; $display("FAIL over_final_scoreR got %0d exp 7", scoreR); end
    checks++; if (hexR !== 7'b1111000) begin errors++; $display("FAIL over_hexR got %b exp 1111000", hexR); end
    checks++; if (gameOver !== 1'b1) begin errors++; $display("FAIL over_gameOver got %b exp 1", gameOver); end
    checks++; if (winnerLeft !== 1'b0) begin errors++; $display("FAIL over_winnerLeft got %b exp 0", winnerLeft); end
    for (int i = 0; i < 12; i++) begin
      rightEnd = 1'b1; R = ($urandom_range(1) == 1); L = ($urandom_range(3) == 0);
      tick();
      checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL frozen_pa got %b exp 0", playAgain); end
      checks++; if (scoreR !== 3'd7 || scoreL !== 3'd0) begin errors++; $display("FAIL frozen_scores got %0d/%0d exp 0/7", scoreL, scoreR); end
      checks++; if (gameOver !== 1'b1) begin errors++; $display("FAIL frozen_gameOver got %b exp 1", gameOver); end
    end
    R = 1'b0; L = 1'b0; rightEnd = 1'b0;
  endtask

`ifdef VICTORY_HOLD_EN
  task automatic test_hold_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    leftEnd = 1'b1; L = 1'b1;
    tick();  // enters hold
    L = 1'b0; leftEnd = 1'b0;
    tick();  // second hold cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (scoreL !== 3'd0 || scoreR !== 3'd0) begin errors++; $display("FAIL hold_reset_scores got %0d/%0d exp 0/0", scoreL, scoreR); end
    for (int i = 0; i < HOLD + 4; i++) begin
      tick();
      checks++; if (playAgain !== 1'b0) begin errors++; $display("FAIL hold_reset_pa got %b exp 0", playAgain); end
    end
  endtask
`endif

  task automatic test_random();
    bit exp_go;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      L        = ($urandom_range(3) == 0);
      R        = ($urandom_range(3) == 0);
      leftEnd  = ($urandom_range(2) == 0);
      rightEnd = ($urandom_range(2) == 0);
      reset    = ($urandom_range(79) == 0);
      tick();
      exp_go = (m_over_at >= 0) && (cyc >= m_over_at);
      checks++; if (scoreL !== m_l[2:0]) begin errors++; $display("FAIL rnd_scoreL cyc %0d got %0d exp %0d", cyc, scoreL, m_l); end
      checks++; if (scoreR !== m_r[2:0]) begin errors++; $display("FAIL rnd_scoreR cyc %0d got %0d exp %0d", cyc, scoreR, m_r); end
      checks++; if (hexL !== exp_hex(m_l)) begin errors++; $display("FAIL rnd_hexL cyc %0d got %b exp %b", cyc, hexL, exp_hex(m_l)); end
      checks++; if (hexR !== exp_hex(m_r)) begin errors++; $display("FAIL rnd_hexR cyc %0d got %b exp %b", cyc, hexR, exp_hex(m_r)); end
      checks++; if (playAgain !== (cyc == m_pa_at)) begin errors++; $display("FAIL rnd_pa cyc %0d got %b exp %b", cyc, playAgain, (cyc == m_pa_at)); end
      checks++; if (gameOver !== exp_go) begin errors++; $display("FAIL rnd_gameOver cyc %0d got %b exp %b", cyc, gameOver, exp_go); end
      checks++; if (winnerLeft !== (exp_go & m_last_left)) begin errors++; $display("FAIL rnd_winnerLeft cyc %0d got %b exp %b", cyc, winnerLeft, exp_go & m_last_left); end
    end
    reset = 1'b0; L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_win();
    test_tie();
    test_match_over();
`ifdef VICTORY_HOLD_EN
    test_hold_reset();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
